cla_4bit: RTL and testbench
===========================

Name: cla_4bit

Overview:
- 4-bit carry-lookahead adder with registered outputs; computes a + b + cin.
- All carries come from generate/propagate lookahead equations, with no ripple chain.
- Exports group propagate/generate so that several instances can be cascaded by a higher-level lookahead unit.
- Used as an arithmetic leaf cell in datapaths that need a 1-cycle, fixed-latency 4-bit add.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a, b, cin this cycle
- a  input  4  addend A, unsigned
- b  input  4  addend B, unsigned
- cin  input  1  carry in
- s  output  4  registered sum bits
- cout  output  1  registered carry out (c4)
- grp_p  output  1  registered group propagate
- grp_g  output  1  registered group generate
- out_valid  output  1  registered; high one cycle after an accepted in_valid

Behaviour:
- Bit terms, i = 0..3:
  - g_i = a_i & b_i
  - p_i = a_i ^ b_i
- Carries, all computed in parallel:
  - c0 = cin
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
- Sum: s_i = p_i ^ c_i.
- Group terms:
  - grp_p = p3·p2·p1·p0
  - grp_g = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - Both are independent of cin.
- Arithmetic contract: {cout, s} equals the 5-bit sum a + b + cin for all 512 input combinations.
- Latency: exactly 1 clock.
  - If in_valid is high at edge N, then s, cout, grp_p, grp_g reflect those inputs after edge N, and out_valid is high for that cycle.
  - If in_valid is low at an edge, data registers hold their previous values and out_valid goes low.
- Back-to-back operation: a new operation is accepted every cycle. There is no stall and no backpressure.
- Reset:
  - When rst is high at a rising edge, s=0, cout=0, grp_p=0, grp_g=0, out_valid=0.
  - Reset takes priority over in_valid asserted in the same cycle; that operation is discarded.
  - Reset asserted mid-stream clears all outputs on the next edge.
- Boundary cases:
  - 0xF + 0x0 + 1 must produce s=0x0, cout=1 through pure propagate (the carry path through all four p_i).
  - 0x0 + 0x0 + 0 must produce all outputs 0, with grp_p=0.
- X-handling: X on a, b or cin while in_valid=0 must not affect the outputs.

Optional Feature:
- Macro: CLA_4BIT_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered, same latency and reset value 0 as s).
  - ovf = c4 ^ c3, i.e. two's-complement signed overflow when a and b are treated as signed 4-bit values.
  - ovf holds together with s when in_valid is low.
- When undefined:
  - The port does not exist and no related logic is generated.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=0xF, b=0xF, cin=1. Required: s=0, cout=0, grp_p=0, grp_g=0, out_valid=0 throughout.
- Basic add: a=0x5, b=0x3, cin=0, in_valid=1. Required next cycle: s=0x8, cout=0, grp_p=0, grp_g=0, out_valid=1.
- Full propagate: a=0x9, b=0x6, cin=1. Required: s=0x0, cout=1, grp_p=1, grp_g=0. Repeat with cin=0. Required: s=0xF, cout=0.
- Generate / overflow: a=0xF, b=0x1, cin=0. Required: s=0x0, cout=1, grp_g=1. With CLA_4BIT_OVF_EN, a=0x7, b=0x1, cin=0 requires s=0x8, ovf=1.
- Hold: issue a=0x2, b=0x2, cin=0, then drop in_valid and change a/b to 0xA/0xB. Required: s stays 0x4, cout=0, out_valid=0 on the following cycle.
- Random/exhaustive: 512 combinations back-to-back, plus 80 random vectors. Each output compared one cycle later against {cout, s} = a + b + cin, with out_valid=1 every cycle.

Source files
------------

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead adder with a fixed 1-cycle registered output.
// Computes {cout, s} = a + b + cin. All carries come from flat generate/propagate
// sum-of-products terms, so there is no ripple chain. Group propagate/generate
// are exported so that a higher-level lookahead unit can cascade several instances.
//
// Optional feature macro: CLA_4BIT_OVF_EN adds the registered signed-overflow output ovf.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; takes priority over in_valid
//   in_valid   in   qualifies a, b, cin this cycle
//   a, b       in   4-bit unsigned addends
//   cin        in   carry in
//   s          out  registered sum bits; holds while in_valid is low
//   cout       out  registered carry out (c4)
//   grp_p      out  registered group propagate (independent of cin)
//   grp_g      out  registered group generate  (independent of cin)
//   out_valid  out  registered; high one cycle after an accepted in_valid
//   ovf        out  (CLA_4BIT_OVF_EN only) registered two's-complement overflow, c4 ^ c3
module cla_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       grp_p,
  output logic       grp_g,
  output logic       out_valid
`ifdef CLA_4BIT_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam int unsigned W = 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic [W-1:0] s_d;
  logic         grp_p_d;
  logic         grp_g_d;

  logic [W-1:0] s_q;
  logic         cout_q;
  logic         grp_p_q;
  logic         grp_g_q;
  logic         out_valid_q;

  // Per-bit generate and propagate terms.
  assign g = a & b;
  assign p = a ^ b;

  // Every carry is an independent two-level expression of g, p and cin.
  always_comb begin
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
  end

  // Sum and cin-independent group terms.
  always_comb begin
    s_d     = p ^ c[W-1:0];
    grp_p_d = &p;
    grp_g_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

  // Output registers: data loads only on accepted operations, valid follows in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      grp_p_q     <= 1'b0;
      grp_g_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        s_q     <= s_d;
        cout_q  <= c[W];
        grp_p_q <= grp_p_d;
        grp_g_q <= grp_g_d;
      end
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign grp_p     = grp_p_q;
  assign grp_g     = grp_g_q;
  assign out_valid = out_valid_q;

`ifdef CLA_4BIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_d = c[W] ^ c[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_4bit.sv
// Testbench for cla_4bit: directed vectors with literal expectations, plus an
// arithmetic reference model compared against the DUT on every cycle after reset.
module tb_cla_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       grp_p;
  logic       grp_g;
  logic       out_valid;
`ifdef CLA_4BIT_OVF_EN
  logic       ovf;
`endif

  int n_vec;
  int n_err;

  cla_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .grp_p     (grp_p),
    .grp_g     (grp_g),
    .out_valid (out_valid)
`ifdef CLA_4BIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the inputs seen at each edge.
  logic       armed;
  logic [3:0] m_s;
  logic       m_cout;
  logic       m_gp;
  logic       m_gg;
  logic       m_ov;
  logic       m_ovf;

  initial armed = 1'b0;

  always @(posedge clk) begin
    int sum;
    int sa;
    int sb;
    int ssum;
    if (rst) begin
      m_s = 4'h0; m_cout = 1'b0; m_gp = 1'b0; m_gg = 1'b0; m_ov = 1'b0; m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      m_ov = in_valid;
      if (in_valid) begin
        sum    = int'(a) + int'(b) + int'(cin);
        m_s    = 4'(sum % 16);
        m_cout = (sum >= 16);
        m_gp   = ((a ^ b) == 4'hF);
        m_gg   = ((int'(a) + int'(b)) >= 16);
        sa     = a[3] ? int'(a) - 16 : int'(a);
        sb     = b[3] ? int'(b) - 16 : int'(b);
        ssum   = sa + sb + int'(cin);
        m_ovf  = (ssum > 7) || (ssum < -8);
      end
    end
    #1;
    if (armed) begin
      chk("model_s",         8'(s),         8'(m_s));
      chk("model_cout",      8'(cout),      8'(m_cout));
      chk("model_grp_p",     8'(grp_p),     8'(m_gp));
      chk("model_grp_g",     8'(grp_g),     8'(m_gg));
      chk("model_out_valid", 8'(out_valid), 8'(m_ov));
`ifdef CLA_4BIT_OVF_EN
      chk("model_ovf",       8'(ovf),       8'(m_ovf));
`endif
    end
  end

  // Drive one input vector just after the falling edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] av,
                       input logic [3:0] bv, input logic cv);
    @(negedge clk);
    rst = r; in_valid = v; a = av; b = bv; cin = cv;
  endtask

  // Wait until the following falling edge so the next rising edge has registered.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] es, input logic ec,
                            input logic ep, input logic eg, input logic ev);
    chk({nm, "_s"},         8'(s),         8'(es));
    chk({nm, "_cout"},      8'(cout),      8'(ec));
    chk({nm, "_grp_p"},     8'(grp_p),     8'(ep));
    chk({nm, "_grp_g"},     8'(grp_g),     8'(eg));
    chk({nm, "_out_valid"}, 8'(out_valid), 8'(ev));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;

    // Reset held two cycles while a valid operation is presented.
    drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    settle(); expect_out("reset1", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle(); expect_out("reset2", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 4'h5, 4'h3, 1'b0);
    settle(); expect_out("basic", 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 4'h9, 4'h6, 1'b1);
    settle(); expect_out("prop_c1", 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 4'h9, 4'h6, 1'b0);
    settle(); expect_out("prop_c0", 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    settle(); expect_out("f_plus_cin", 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 4'hF, 4'h1, 1'b0);
    settle(); expect_out("generate", 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);

`ifdef CLA_4BIT_OVF_EN
    drive(1'b0, 1'b1, 4'h7, 4'h1, 1'b0);
    settle();
    expect_out("ovf_case", 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_case_ovf", 8'(ovf), 8'h1);
`endif

    // Hold: valid drops and inputs change, registered data must stay.
    drive(1'b0, 1'b1, 4'h2, 4'h2, 1'b0);
    settle(); expect_out("hold_load", 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'hA, 4'hB, 1'b1);
    settle(); expect_out("hold_idle", 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exhaustive back-to-back; the model process checks every cycle.
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 1'b1, i[3:0], i[7:4], i[8]);
    end
    settle();
    expect_out("exh_last", 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 80; k++) begin
      drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end

    // Mid-stream reset discards the concurrent operation.
    drive(1'b1, 1'b1, 4'hC, 4'h7, 1'b1);
    settle(); expect_out("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
    settle(); expect_out("zero", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    settle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
